// File: rtl/cpu_pkg.sv
// Shared CPU types for the unified memory port arbiter.
// Holds FSM/owner encodings and default timing constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-macro signals of the shared memory port.
// slave is the arbiter view, master the requester/memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_data_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ack_o;
  logic [DATA_W-1:0] dm_rdata_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              stall_if_o;
  logic              stall_mem_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_ack_o, if_data_o,
    output dm_ack_o, dm_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output stall_if_o, stall_mem_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_ack_o, if_data_o,
    input  dm_ack_o, dm_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  stall_if_o, stall_mem_o
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory macro between the IF and MEM stages.
// Data wins arbitration unless fetch has waited STARVE_MAX grants.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  arb_state_t        state_q;
  arb_state_t        state_nxt;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  streak_q;
  logic [DATA_W-1:0] if_data_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              grant;
  logic              grant_if;

  always_comb begin
    state_nxt = state_q;
    grant     = 1'b0;
    grant_if  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req_i | bus.dm_req_i) begin
          state_nxt = ISSUE;
          grant     = 1'b1;
          grant_if  = bus.if_req_i &
                      (~bus.dm_req_i | (streak_q == SMAX));
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (cnt_q == 4'd1) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      streak_q   <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (grant) begin
        owner_q <= grant_if ? OWN_IF : OWN_DM;
        addr_q  <= grant_if ? bus.if_addr_i : bus.dm_addr_i;
        we_q    <= ~grant_if & bus.dm_we_i;
        wdata_q <= grant_if ? '0 : bus.dm_wdata_i;
        // streak counts data grants that made a fetch wait
        if (grant_if || !bus.if_req_i) begin
          streak_q <= '0;
        end else if (streak_q != SMAX) begin
          streak_q <= streak_q + 4'd1;
        end
      end
      if (state_q == ISSUE) begin
        cnt_q <= LAT;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1 && !we_q) begin
          if (owner_q == OWN_IF) if_data_q  <= bus.mem_rdata_i;
          else                   dm_rdata_q <= bus.mem_rdata_i;
        end
      end
    end
  end

  assign bus.mem_en_o    = (state_q == ISSUE);
  assign bus.mem_we_o    = (state_q == ISSUE) & we_q;
  assign bus.mem_addr_o  = (state_q == ISSUE) ? addr_q : '0;
  assign bus.mem_wdata_o = (state_q == ISSUE) ? wdata_q : '0;

  assign bus.if_ack_o   = (state_q == RESP) & (owner_q == OWN_IF);
  assign bus.dm_ack_o   = (state_q == RESP) & (owner_q == OWN_DM);
  assign bus.if_data_o  = if_data_q;
  assign bus.dm_rdata_o = dm_rdata_q;

  assign bus.stall_if_o  = bus.if_req_i & ~bus.if_ack_o;
  assign bus.stall_mem_o = bus.dm_req_i & ~bus.dm_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing cases,
// latency variants and randomized IF/MEM traffic.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = cpu_pkg::MEM_LAT_DEF;
  localparam int SMAX = cpu_pkg::STARVE_MAX_DEF;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          sec_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // memory macro model (environment) and reference memory (expectations)
  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] exp_mem [logic [AW-1:0]];
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];
  logic [DW-1:0] last_load = '0;
  logic          rd_pend = 1'b0;
  int unsigned   rd_due = 0;
  logic [DW-1:0] rd_data = '0;

  function automatic logic [DW-1:0] exp_val(input logic [AW-1:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : rom(a);
  endfunction

  always @(negedge clk) begin
    bus.mem_rdata_i = (rd_pend && cyc == rd_due) ? rd_data : DW'($urandom);
    if (rst_n && bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        chk1("mem_wr_legal", bus.dm_req_i && bus.dm_we_i &&
             bus.mem_addr_o == bus.dm_addr_i &&
             bus.mem_wdata_o == bus.dm_wdata_i, 1'b1);
        mem[bus.mem_addr_o] = bus.mem_wdata_o;
      end else begin
        chk1("mem_rd_legal",
             (bus.if_req_i && bus.mem_addr_o == bus.if_addr_i) ||
             (bus.dm_req_i && !bus.dm_we_i &&
              bus.mem_addr_o == bus.dm_addr_i), 1'b1);
        rd_pend = 1'b1;
        rd_due  = cyc + LAT;
        rd_data = mem.exists(bus.mem_addr_o) ? mem[bus.mem_addr_o]
                                             : rom(bus.mem_addr_o);
      end
    end
  end

  // monitor: pops expected responses whenever an ack appears
  logic [DW-1:0] hold_if = '0;
  logic [DW-1:0] hold_dm = '0;
  logic [DW-1:0] e_if, e_dm;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_if = '0;
      hold_dm = '0;
    end else begin
      if (bus.if_ack_o) begin
        if (if_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL if_ack_spurious got=1 exp=0 t=%0t", $time);
        end else begin
          e_if = if_q.pop_front();
          chkw("if_data", bus.if_data_o, e_if);
        end
        hold_if = bus.if_data_o;
      end else begin
        chkw("if_data_hold", bus.if_data_o, hold_if);
      end
      if (bus.dm_ack_o) begin
        if (dm_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dm_ack_spurious got=1 exp=0 t=%0t", $time);
        end else begin
          e_dm = dm_q.pop_front();
          chkw("dm_rdata", bus.dm_rdata_o, e_dm);
        end
        hold_dm = bus.dm_rdata_o;
      end else begin
        chkw("dm_rdata_hold", bus.dm_rdata_o, hold_dm);
      end
      chk1("stall_if", bus.stall_if_o, bus.if_req_i & ~bus.if_ack_o);
      chk1("stall_mem", bus.stall_mem_o, bus.dm_req_i & ~bus.dm_ack_o);
      chk1("ack_exclusive", bus.if_ack_o & bus.dm_ack_o, 1'b0);
    end
  end

  logic outs_any;
  assign outs_any = |{bus.if_ack_o, bus.if_data_o, bus.dm_ack_o,
                      bus.dm_rdata_o, bus.mem_en_o, bus.mem_we_o,
                      bus.mem_addr_o, bus.mem_wdata_o,
                      bus.stall_if_o, bus.stall_mem_o};

  task automatic issue_if(input logic [AW-1:0] a);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = a;
    if_q.push_back(exp_val(a));
  endtask

  task automatic issue_dm(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = we;
    bus.dm_addr_i  = a;
    bus.dm_wdata_i = d;
    if (we) begin
      exp_mem[a] = d;
    end else begin
      last_load = exp_val(a);
    end
    dm_q.push_back(last_load);
  endtask

  task automatic issue_dm_rand();
    logic [AW-1:0] a;
    a = 32'h1000 + 4 * $urandom_range(0, 7);
    issue_dm(1'($urandom_range(0, 1)), a, DW'($urandom));
  endtask

  task automatic wait_ack(input bit is_if, input string nm);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    while (!got && n < TMO) begin
      @(negedge clk);
      got = is_if ? bus.if_ack_o : bus.dm_ack_o;
      n++;
    end
    chk1({nm, "_ack_seen"}, got, 1'b1);
    @(posedge clk); #1;
    if (is_if) bus.if_req_i = 1'b0;
    else       bus.dm_req_i = 1'b0;
  endtask

  // request presented at cycle 0 in IDLE; ack expected at cycle lat
  task automatic expect_ack(input string nm, input bit is_if,
                            input int lat, input logic we);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      chk1({nm, "_ack"}, is_if ? bus.if_ack_o : bus.dm_ack_o, c == lat);
      chk1({nm, "_en"}, bus.mem_en_o, c == 1);
      if (c == 1) chk1({nm, "_we"}, bus.mem_we_o, we);
    end
    @(posedge clk); #1;
    if (is_if) bus.if_req_i = 1'b0;
    else       bus.dm_req_i = 1'b0;
  endtask

  for (genvar g = 0; g < 2; g++) begin : lat_g
    localparam int L = (g == 0) ? 1 : 15;
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sb ();
    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SMAX)
    ) sdut (
      .clk_i(clk),
      .rst_i(rst_n),
      .bus  (sb)
    );
    int unsigned   due = 0;
    logic [AW-1:0] ra = '0;

    // read data is valid only in the single cycle L after mem_en_o
    always @(negedge clk) begin
      sb.mem_rdata_i = (cyc == due) ? rom(ra) : DW'($urandom);
      if (sb.mem_en_o) begin
        due = cyc + L;
        ra  = sb.mem_addr_o;
      end
    end

    initial begin
      logic [AW-1:0] a;
      a = AW'(32'h100 + g * 4);
      sb.if_req_i   = 1'b0;
      sb.if_addr_i  = '0;
      sb.dm_req_i   = 1'b0;
      sb.dm_we_i    = 1'b0;
      sb.dm_addr_i  = '0;
      sb.dm_wdata_i = '0;
      wait (rst_n === 1'b1);
      @(posedge clk); #1;
      sb.if_req_i  = 1'b1;
      sb.if_addr_i = a;
      for (int c = 0; c <= L + 2; c++) begin
        @(negedge clk);
        chk1($sformatf("t6_lat%0d_en", L), sb.mem_en_o, c == 1);
        chk1($sformatf("t6_lat%0d_ack", L), sb.if_ack_o, c == L + 2);
        if (c == L + 1)
          chkw($sformatf("t6_lat%0d_early", L), sb.if_data_o, '0);
        if (c == L + 2)
          chkw($sformatf("t6_lat%0d_data", L), sb.if_data_o, rom(a));
      end
      @(posedge clk); #1;
      sb.if_req_i = 1'b0;
      sec_done++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned prev;
    bit          got, was_if;
    int          n;

    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;
    mem[32'h10]     = 32'h0050_0093;
    exp_mem[32'h10] = 32'h0050_0093;

    repeat (2) @(posedge clk);
    #1;
    chk1("reset_outs_zero", outs_any, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: fetch only
    issue_if(32'h10);
    expect_ack("t1_fetch", 1'b1, LAT + 2, 1'b0);

    // 2: store then load, MEM_LAT+3 apart
    issue_dm(1'b1, 32'h20, 32'hDEAD_BEEF);
    expect_ack("t2_store", 1'b0, LAT + 2, 1'b1);
    issue_dm(1'b0, 32'h20, '0);
    expect_ack("t2_load", 1'b0, LAT + 2, 1'b0);

    // 3: simultaneous requests, data first
    issue_if(32'h14);
    issue_dm(1'b0, 32'h20, '0);
    for (int c = 0; c <= 2 * LAT + 5; c++) begin
      @(negedge clk);
      chk1("t3_dm_ack", bus.dm_ack_o, c == LAT + 2);
      chk1("t3_if_ack", bus.if_ack_o, c == 2 * LAT + 5);
      chk1("t3_en", bus.mem_en_o, c == 1 || c == LAT + 4);
      if (c == LAT + 2) begin
        @(posedge clk); #1;
        bus.dm_req_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    bus.if_req_i = 1'b0;

    // 4: both held; every (SMAX+1)-th grant goes to fetch
    issue_if(AW'(4 * $urandom_range(0, 63)));
    issue_dm_rand();
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      got = 1'b0;
      while (!got && n < TMO) begin
        @(negedge clk);
        got = bus.if_ack_o | bus.dm_ack_o;
        n++;
      end
      chk1("t4_ack_seen", got, 1'b1);
      chk1("t4_order", bus.if_ack_o, (k % (SMAX + 1)) == SMAX);
      if (k > 0) chkw("t4_spacing", cyc - prev, DW'(LAT + 3));
      prev = cyc;
      was_if = bus.if_ack_o;
      @(posedge clk); #1;
      if (k < 9) begin
        if (was_if) issue_if(AW'(4 * $urandom_range(0, 63)));
        else        issue_dm_rand();
      end else begin
        if (was_if) bus.if_req_i = 1'b0;
        else        bus.dm_req_i = 1'b0;
      end
    end
    wait_ack(1'b0, "t4_drain");

    for (int i = 0; i < 100 && sec_done < 2; i++) @(posedge clk);
    chk1("t6_done", sec_done == 2, 1'b1);
    @(posedge clk); #1;

    // 5: reset while in WAIT
    issue_if(32'h40);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.if_req_i = 1'b0;
    if_q.delete();
    #1;
    chk1("t5_outs_zero", outs_any, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk1("t5_no_ack_rst", bus.if_ack_o | bus.dm_ack_o, 1'b0);
    end
    #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk1("t5_no_ack", bus.if_ack_o | bus.dm_ack_o, 1'b0);
    end
    @(posedge clk); #1;
    issue_if(32'h40);
    expect_ack("t5_retry", 1'b1, LAT + 2, 1'b0);

    // random traffic on both ports
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_if(AW'(4 * $urandom_range(0, 63)));
          wait_ack(1'b1, "rnd_if");
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          issue_dm_rand();
          wait_ack(1'b0, "rnd_dm");
        end
      end
    join

    repeat (4) @(posedge clk);
    chk1("queues_empty", if_q.size() == 0 && dm_q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
